// File: rtl/param_seq_det_pkg.sv
// rtl/param_seq_det_pkg.sv - shared FSM state encoding and default pattern for param_seq_det
//
// Contents:
//   state_t          - two-state detector FSM encoding (ST_FILL, ST_ARMED)
//   DEFAULT_RST_PAT  - pattern loaded at reset, first-received bit in the MSB
package param_seq_det_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_FILL  = 1'b0;
    localparam state_t ST_ARMED = 1'b1;

    localparam logic [5:0] DEFAULT_RST_PAT = 6'b010110;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit saturating up-counter with synchronous clear
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, count -> 0
//   inc   - add one this cycle (ignored once the counter is at all-ones)
//   clr   - synchronous clear; wins over inc
//   count - current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/param_seq_det.sv
// rtl/param_seq_det.sv - programmable masked serial pattern detector with match counter
//
// Ports:
//   clk, rst     - clock (rising edge) and asynchronous active-high reset
//   serial_in    - serial data bit, sampled when in_valid=1
//   in_valid     - qualifies serial_in
//   overlap      - 1: matches may share bits; 0: search restarts after a match
//   pat_load     - one-cycle strobe loading pat_in/mask_in and restarting the search
//   pat_in       - new pattern, first-received bit in the MSB
//   mask_in      - per-bit compare enable (0 = don't care)
//   clr_count    - synchronous clear of match_count
//   serial_out   - one-cycle match pulse, one cycle after the matching bit
//   match_count  - saturating match count
//   armed        - history register holds PAT_W valid bits
module param_seq_det
    import param_seq_det_pkg::*;
#(
    parameter int               PAT_W   = 6,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEFAULT_RST_PAT),
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [PAT_W-1:0] mask_in,
    input  logic             clr_count,
    output logic             serial_out,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int              FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  mask_q, mask_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    state_t            state_q, state_d;
    logic              serial_out_q, serial_out_d;

    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    always_comb begin
        hist_d     = hist_q;
        pat_d      = pat_q;
        mask_d     = mask_q;
        fill_d     = fill_q;
        match      = 1'b0;
        hist_shift = {hist_q[PAT_W-2:0], serial_in};
        // Fill saturates at PAT_W so an overlapping search stays armed.
        fill_inc   = (fill_q == FULL) ? fill_q : fill_q + FILL_W'(1);

        if (pat_load) begin
            // A bit arriving alongside a load belongs to neither pattern; drop it.
            pat_d  = pat_in;
            mask_d = mask_in;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_shift;
            match  = (fill_inc == FULL) && (((hist_shift ^ pat_q) & mask_q) == '0);
            fill_d = (match && !overlap) ? '0 : fill_inc;
        end

        state_d      = (fill_d == FULL) ? ST_ARMED : ST_FILL;
        serial_out_d = match;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q       <= '0;
            pat_q        <= RST_PAT;
            mask_q       <= '1;
            fill_q       <= '0;
            state_q      <= ST_FILL;
            serial_out_q <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            pat_q        <= pat_d;
            mask_q       <= mask_d;
            fill_q       <= fill_d;
            state_q      <= state_d;
            serial_out_q <= serial_out_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (match),
        .clr  (clr_count),
        .count(match_count)
    );

    assign serial_out = serial_out_q;
    assign armed      = (state_q == ST_ARMED);

endmodule

// File: tb/tb_param_seq_det.sv
// tb/tb_param_seq_det.sv - self-checking bench for param_seq_det (default and CNT_W=2 instances)
module tb_param_seq_det;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b0;
    logic       in_valid = 1'b0;
    logic       overlap = 1'b0;
    logic       pat_load = 1'b0;
    logic [5:0] pat_in = '0;
    logic [5:0] mask_in = '0;
    logic       clr_count = 1'b0;

    logic       serial_out_a, armed_a;
    logic [7:0] match_count_a;
    logic       serial_out_b, armed_b;
    logic [1:0] match_count_b;

    always #5 clk = ~clk;

    param_seq_det dut_a (
        .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in),
        .clr_count(clr_count), .serial_out(serial_out_a), .match_count(match_count_a),
        .armed(armed_a)
    );

    param_seq_det #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in),
        .clr_count(clr_count), .serial_out(serial_out_b), .match_count(match_count_b),
        .armed(armed_b)
    );

    int n_pass = 0;
    int n_total = 0;
    int pulses = 0;

    // Reference model: the valid bits seen since the last restart, oldest first.
    bit         mq[$];
    logic [5:0] m_pat = 6'b010110;
    logic [5:0] m_mask = 6'b111111;
    int         m_cnt_a = 0;
    int         m_cnt_b = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pat   = 6'b010110;
        m_mask  = 6'b111111;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic step(input logic sin, input logic vld, input logic ovl, input logic ld,
                        input logic [5:0] pin, input logic [5:0] min, input logic clr);
        bit         exp_pulse;
        logic [5:0] w;
        @(negedge clk);
        serial_in = sin; in_valid = vld; overlap = ovl; pat_load = ld;
        pat_in = pin; mask_in = min; clr_count = clr;
        @(posedge clk);
        #1;
        exp_pulse = 1'b0;
        if (ld) begin
            m_pat  = pin;
            m_mask = min;
            mq.delete();
        end else if (vld) begin
            mq.push_back(sin);
            if (mq.size() > 6) void'(mq.pop_front());
            if (mq.size() == 6) begin
                for (int i = 0; i < 6; i++) w[5-i] = mq[i];
                if (((w ^ m_pat) & m_mask) == 6'd0) begin
                    exp_pulse = 1'b1;
                    if (!ovl) mq.delete();
                end
            end
        end
        if (clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (exp_pulse) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
        end
        chk("serial_out_a", 32'(serial_out_a), 32'(exp_pulse));
        chk("serial_out_b", 32'(serial_out_b), 32'(exp_pulse));
        chk("match_count_a", 32'(match_count_a), 32'(m_cnt_a));
        chk("match_count_b", 32'(match_count_b), 32'(m_cnt_b));
        chk("armed_a", 32'(armed_a), 32'(mq.size() == 6));
        chk("armed_b", 32'(armed_b), 32'(mq.size() == 6));
        if (serial_out_a) pulses++;
    endtask

    task automatic send(input logic b, input logic ovl);
        step(b, 1'b1, ovl, 1'b0, 6'd0, 6'd0, 1'b0);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input logic ovl);
        for (int i = n - 1; i >= 0; i--) send(v[i], ovl);
    endtask

    task automatic gap();
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
    endtask

    task automatic load(input logic [5:0] p, input logic [5:0] m);
        step(1'b0, 1'b0, 1'b0, 1'b1, p, m, 1'b0);
    endtask

    // Asserts rst wherever the caller is in the cycle and checks outputs before any clock edge.
    task automatic do_reset();
        serial_in = 1'b0; in_valid = 1'b0; overlap = 1'b0; pat_load = 1'b0;
        pat_in = '0; mask_in = '0; clr_count = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_serial_out_a", 32'(serial_out_a), 32'd0);
        chk("rst_match_count_a", 32'(match_count_a), 32'd0);
        chk("rst_armed_a", 32'(armed_a), 32'd0);
        chk("rst_match_count_b", 32'(match_count_b), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_serial_out_a", 32'(serial_out_a), 32'd0);
        chk("rst_hold_armed_a", 32'(armed_a), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1;
        do_reset();

        // Default pattern, no overlap: one pulse after the 6th bit.
        pulses = 0;
        send_bits(32'b010110, 6, 1'b0);
        chk("r034_pulses", 32'(pulses), 32'd1);
        chk("r034_count", 32'(match_count_a), 32'd1);

        // Alternating pattern with and without overlap.
        load(6'b101010, 6'b111111);
        pulses = 0;
        send_bits(32'b10101010, 8, 1'b1);
        chk("r035_ovl_pulses", 32'(pulses), 32'd2);
        load(6'b101010, 6'b111111);
        pulses = 0;
        send_bits(32'b10101010, 8, 1'b0);
        chk("r035_noovl_pulses", 32'(pulses), 32'd1);

        // Gaps between bits 3 and 4 are transparent.
        load(6'b010110, 6'b111111);
        pulses = 0;
        send_bits(32'b010, 3, 1'b0);
        gap(); gap(); gap();
        chk("r036_gap_pulses", 32'(pulses), 32'd0);
        send_bits(32'b110, 3, 1'b0);
        chk("r036_pulses", 32'(pulses), 32'd1);

        // Masked compare: middle bits are don't-care.
        load(6'b010110, 6'b110011);
        pulses = 0;
        send_bits(32'b011010, 6, 1'b0);
        chk("r037_match", 32'(pulses), 32'd1);
        pulses = 0;
        send_bits(32'b110110, 6, 1'b0);
        chk("r037_nomatch", 32'(pulses), 32'd0);

        // All-zero mask, small counter saturates; clear wins over a coincident match.
        step(1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1);
        send_bits(32'hA5, 8, 1'b1);
        chk("r038_sat", 32'(match_count_b), 32'd3);
        send_bits(32'b01, 2, 1'b1);
        chk("r038_sat_hold", 32'(match_count_b), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 1'b1);
        chk("r038_clr_pulse", 32'(serial_out_b), 32'd1);
        chk("r038_clr_count", 32'(match_count_b), 32'd0);

        // Reset mid-stream discards partial history.
        load(6'b010110, 6'b111111);
        send_bits(32'b01011, 5, 1'b0);
        #2;
        do_reset();
        pulses = 0;
        send(1'b0, 1'b0);
        chk("r039_no_pulse", 32'(pulses), 32'd0);
        send_bits(32'b010110, 6, 1'b0);
        chk("r039_one_pulse", 32'(pulses), 32'd1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] rp, rm;
            int         r;
            r  = $urandom_range(0, 99);
            rp = 6'($urandom);
            rm = 6'($urandom) | 6'($urandom);
            if (r < 3) begin
                step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, rp, rm, 1'b0);
            end else begin
                step(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), 1'b0,
                     rp, rm, ($urandom_range(0, 40) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
